mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute ALU in the pipelined RV32I core.
- Consumes the ALU result (effective address or arithmetic result), the store operand and the decoded operation.
- Performs loads/stores over a req/ack data-memory port with byte/half/word sizing and sign extension.
- Hands a registered writeback bundle to the register-file write stage; stalls upstream while a memory transaction is outstanding.

Parameters:
XLEN, 32, datapath width; only 32 supported.
TIMEOUT, 255, max cycles waiting for mem_ack before aborting with bus_err.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
valid_in  input  1  execute stage presents a valid instruction
operation  input  12  [9:7]=funct3, [6:0]=opcode, same encoding as the execute stage
alu_res  input  XLEN  ALU result: effective address for load/store, else the writeback value
store_data  input  XLEN  rs2 value, already forwarded
rd_idx  input  5  destination register index
stall  output  1  upstream must hold its outputs this cycle
mem_req  output  1  memory request
mem_we  output  1  1 = store
mem_addr  output  XLEN  word-aligned address (alu_res with [1:0] cleared)
mem_wdata  output  XLEN  store data replicated into the byte lanes
mem_wstrb  output  4  byte enables
mem_rdata  input  XLEN  read data
mem_ack  input  1  memory completes the request this cycle
wb_valid  output  1  writeback bundle valid, one-cycle pulse per instruction
wb_en  output  1  write the register file
wb_rd  output  5  destination index
wb_data  output  XLEN  writeback value
misaligned  output  1  one-cycle pulse: misaligned access, instruction dropped
bus_err  output  1  one-cycle pulse: timeout, instruction dropped

Behaviour:
- Reset (async): all outputs 0, FSM=IDLE, timeout counter 0. Reset mid-transaction drops mem_req immediately; the pending instruction is lost.
- Operation classes:
  - LOAD: opcode 0000011; funct3 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - STORE: opcode 0100011; funct3 000 sb, 001 sh, 010 sw.
  - BRANCH: opcode 1100011.
  - Any other opcode is PASS.
- FSM states: IDLE, ACCESS, DONE.
- IDLE with valid_in:
  - PASS → next cycle wb_valid=1, wb_en=(rd_idx!=0), wb_data=alu_res.
  - BRANCH → next cycle wb_valid=1, wb_en=0.
  - LOAD/STORE aligned → capture op/addr/data/rd; go to ACCESS; mem_req=1 from the next cycle.
  - Misaligned → no request; next cycle misaligned=1, wb_valid=1, wb_en=0. Half is misaligned if addr[0]=1; word if addr[1:0]!=0.
  - Undefined funct3 under LOAD/STORE → treated as misaligned.
- ACCESS:
  - mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb held stable until mem_ack.
  - mem_ack=1 → drop mem_req next cycle, register the result, go to DONE.
  - Counter increments each cycle without ack; on reaching TIMEOUT → bus_err pulse, wb_valid=1, wb_en=0, back to IDLE.
- DONE (one cycle): wb_valid=1; loads set wb_en=(rd!=0); stores set wb_en=0. Returns to IDLE, where a new valid_in is accepted the same cycle.
- Load latency: accept cycle N, mem_req at N+1, ack at cycle A ≥ N+1, wb_valid at A+1.
- stall = (state==ACCESS) | (state==IDLE & valid_in & aligned load/store). It is combinational so upstream holds from the accept cycle onward.
- Store lanes:
  - sb: wdata={4{b}}, wstrb=1<<addr[1:0].
  - sh: wdata={2{h}}, wstrb=addr[1] ? 1100 : 0011.
  - sw: wstrb=1111.
- Load extract: select byte/half lane by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend.
- mem_ack outside ACCESS is ignored.
- wb_rd holds its last value when wb_valid=0.

Decomposition:
- Shared package core_pkg: opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_R, OP_I), funct3 size codes, mem-stage state enum.
- One sub-module: mem_align, purely combinational. It provides store lane/strobe generation, load extract/extend and misalignment detection. The FSM, counter and writeback registers stay in mem_stage.

Test Plan:
- PASS add: valid_in, op=0x033, alu_res=0x0000_1234, rd=5 → next cycle wb_valid=1, wb_en=1, wb_rd=5, wb_data=0x1234, stall never 1.
- lb sign: addr=0x103, mem_rdata=0x80FF_0000, ack 2 cycles after req → wb_data=0xFFFF_FF80. lbu on the same data gives 0x0000_0080. mem_addr=0x100 and stall high until the ack cycle.
- sh: addr=0x202, store_data=0xDEAD_BEEF, immediate ack → mem_we=1, wstrb=1100, wdata=0xBEEF_BEEF, wb_en=0.
- Misaligned lw at 0x101 → no mem_req, misaligned pulse 1 cycle, wb_en=0. Same for sh at 0x003.
- Timeout with TIMEOUT=4, mem_ack held 0 → mem_req high 4 cycles then low, bus_err pulse, FSM back in IDLE, next PASS accepted.
- Reset asserted mid-ACCESS → mem_req, stall and wb_valid go 0 asynchronously. After release, a load at rd=0 completes with wb_en=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcodes, funct3 size codes and the
// memory-stage FSM state type.
package core_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Byte-lane helper for the memory stage: store lane replication and strobes,
// misalignment detection, and load lane extraction with sign/zero extension.
module mem_align
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      wstrb,
  output logic            misaligned,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    wdata = store_data;
    wstrb = 4'b0000;
    case (funct3)
      F3_B: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      F3_H: begin
        wdata = {2{store_data[15:0]}};
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      F3_W:    wstrb = 4'b1111;
      default: ;
    endcase
  end

  // Undefined size codes under LOAD/STORE are reported as misaligned too.
  always_comb begin
    misaligned = 1'b0;
    if (is_load) begin
      case (funct3)
        F3_B, F3_BU: misaligned = 1'b0;
        F3_H, F3_HU: misaligned = addr_lo[0];
        F3_W:        misaligned = (addr_lo != 2'b00);
        default:     misaligned = 1'b1;
      endcase
    end else if (is_store) begin
      case (funct3)
        F3_B:    misaligned = 1'b0;
        F3_H:    misaligned = addr_lo[0];
        F3_W:    misaligned = (addr_lo != 2'b00);
        default: misaligned = 1'b1;
      endcase
    end
  end

  always_comb begin
    case (ld_addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (ld_funct3)
      F3_B:    ld_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_BU:   ld_data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_H:    ld_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_HU:   ld_data = {{(XLEN-16){1'b0}}, half_sel};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues loads/stores over a req/ack port, times
// out stuck requests and produces a registered writeback bundle.
module mem_stage
  import core_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [11:0]     operation,
  input  logic [XLEN-1:0] alu_res,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd_idx,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            wb_valid,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misaligned,
  output logic            bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_load, is_store, is_branch;
  logic       acc_mis, accept, ls_go;
  logic [XLEN-1:0] st_wdata, ld_data;
  logic [3:0]      st_wstrb;
  logic [1:0]      unused_op_bits;

  mem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            ld_q, ld_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic [4:0]      rd_q, rd_d;
  logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic            wb_valid_q, wb_valid_d, wb_en_q, wb_en_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            misaligned_q, misaligned_d, bus_err_q, bus_err_d;

  assign opcode         = operation[6:0];
  assign funct3         = operation[9:7];
  assign unused_op_bits = operation[11:10];
  assign is_load        = (opcode == OP_LOAD);
  assign is_store       = (opcode == OP_STORE);
  assign is_branch      = (opcode == OP_BRANCH);

  mem_align #(.XLEN(XLEN)) u_align (
    .funct3     (funct3),
    .addr_lo    (alu_res[1:0]),
    .is_load    (is_load),
    .is_store   (is_store),
    .store_data (store_data),
    .wdata      (st_wdata),
    .wstrb      (st_wstrb),
    .misaligned (acc_mis),
    .ld_funct3  (f3_q),
    .ld_addr_lo (addr_lo_q),
    .rdata      (mem_rdata),
    .ld_data    (ld_data)
  );

  assign accept = (state_q == ST_IDLE) && valid_in;
  assign ls_go  = (is_load || is_store) && !acc_mis;
  // Combinational so upstream already holds in the cycle the access is accepted.
  assign stall  = !reset && ((state_q == ST_ACCESS) || (accept && ls_go));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ld_d         = ld_q;
    f3_d         = f3_q;
    addr_lo_d    = addr_lo_q;
    rd_d         = rd_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    wb_valid_d   = 1'b0;
    wb_en_d      = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    misaligned_d = 1'b0;
    bus_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          if (is_load || is_store) begin
            if (acc_mis) begin
              misaligned_d = 1'b1;
              wb_valid_d   = 1'b1;
              wb_rd_d      = rd_idx;
            end else begin
              state_d     = ST_ACCESS;
              cnt_d       = '0;
              ld_d        = is_load;
              f3_d        = funct3;
              addr_lo_d   = alu_res[1:0];
              rd_d        = rd_idx;
              mem_req_d   = 1'b1;
              mem_we_d    = is_store;
              mem_addr_d  = {alu_res[XLEN-1:2], 2'b00};
              mem_wdata_d = st_wdata;
              mem_wstrb_d = is_store ? st_wstrb : 4'b0000;
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_en_d    = !is_branch && (rd_idx != 5'd0);
            wb_rd_d    = rd_idx;
            wb_data_d  = alu_res;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          state_d    = ST_DONE;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_en_d    = ld_q && (rd_q != 5'd0);
          wb_rd_d    = rd_q;
          wb_data_d  = ld_q ? ld_data : '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          bus_err_d  = 1'b1;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // The writeback pulse is already registered; valid_in here is the
      // still-held instruction that was just completed.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ld_q         <= 1'b0;
      f3_q         <= 3'b000;
      addr_lo_q    <= 2'b00;
      rd_q         <= 5'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= 4'b0000;
      wb_valid_q   <= 1'b0;
      wb_en_q      <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= '0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ld_q         <= ld_d;
      f3_q         <= f3_d;
      addr_lo_q    <= addr_lo_d;
      rd_q         <= rd_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      wb_valid_q   <= wb_valid_d;
      wb_en_q      <= wb_en_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      misaligned_q <= misaligned_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign wb_valid   = wb_valid_q;
  assign wb_en      = wb_en_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign misaligned = misaligned_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected writebacks are queued when an
// instruction is issued and compared when wb_valid appears.
module tb_mem_stage;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 4;

  localparam logic [11:0] OP_ADD = 12'h033;
  localparam logic [11:0] OP_BEQ = 12'h063;
  localparam logic [11:0] LB     = 12'h003;
  localparam logic [11:0] LH     = 12'h083;
  localparam logic [11:0] LW     = 12'h103;
  localparam logic [11:0] LBU    = 12'h203;
  localparam logic [11:0] LHU    = 12'h283;
  localparam logic [11:0] LD_BAD = 12'h183;
  localparam logic [11:0] SB     = 12'h023;
  localparam logic [11:0] SH     = 12'h0A3;
  localparam logic [11:0] SW     = 12'h123;

  logic            clk = 1'b0;
  logic            reset;
  logic            valid_in;
  logic [11:0]     operation;
  logic [XLEN-1:0] alu_res, store_data;
  logic [4:0]      rd_idx;
  logic            stall, mem_req, mem_we;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]      mem_wstrb;
  logic            mem_ack;
  logic            wb_valid, wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            misaligned, bus_err;

  typedef struct packed {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .operation  (operation),
    .alu_res    (alu_res),
    .store_data (store_data),
    .rd_idx     (rd_idx),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .wb_valid   (wb_valid),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .misaligned (misaligned),
    .bus_err    (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [11:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] rd);
    valid_in   = 1'b1;
    operation  = op;
    alu_res    = a;
    store_data = sd;
    rd_idx     = rd;
  endtask

  task automatic idle_in();
    valid_in   = 1'b0;
    operation  = '0;
    alu_res    = '0;
    store_data = '0;
    rd_idx     = '0;
  endtask

  task automatic push(input logic en, input logic [4:0] rd, input logic [31:0] d,
                      input logic chk, input logic mis, input logic berr);
    exp_t e;
    e.en   = en;
    e.rd   = rd;
    e.data = d;
    e.chk  = chk;
    e.mis  = mis;
    e.berr = berr;
    q.push_back(e);
  endtask

  // Waits a bounded number of cycles for wb_valid, then compares against the queue head.
  task automatic drain(input string tag);
    exp_t e;
    bit   seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clk);
      if (wb_valid) seen = 1'b1;
    end
    if (!seen) begin
      check({tag, ".wb_valid_timeout"}, 32'(wb_valid), 32'd1);
      return;
    end
    if (q.size() == 0) begin
      check({tag, ".unexpected_wb"}, 32'(q.size()), 32'd1);
      return;
    end
    e = q.pop_front();
    check({tag, ".wb_en"}, 32'(wb_en), 32'(e.en));
    check({tag, ".misaligned"}, 32'(misaligned), 32'(e.mis));
    check({tag, ".bus_err"}, 32'(bus_err), 32'(e.berr));
    if (e.chk) begin
      check({tag, ".wb_rd"}, 32'(wb_rd), 32'(e.rd));
      check({tag, ".wb_data"}, wb_data, e.data);
    end
  endtask

  // Aligned load/store: delay = request cycles before the ack cycle.
  task automatic mem_op(input string tag, input logic [11:0] op, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] rd, input int delay,
                        input logic [31:0] rdata, input logic we, input logic [31:0] wdata,
                        input logic [3:0] wstrb);
    logic [31:0] exp_addr;
    exp_addr = {a[31:2], 2'b00};
    issue(op, a, sd, rd);
    @(negedge clk);
    check({tag, ".stall_accept"}, 32'(stall), 32'd1);
    check({tag, ".no_req_accept"}, 32'(mem_req), 32'd0);
    tick();
    idle_in();
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check({tag, ".req_wait"}, 32'(mem_req), 32'd1);
      check({tag, ".stall_wait"}, 32'(stall), 32'd1);
      tick();
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(negedge clk);
    check({tag, ".req_ack"}, 32'(mem_req), 32'd1);
    check({tag, ".stall_ack"}, 32'(stall), 32'd1);
    check({tag, ".mem_we"}, 32'(mem_we), 32'(we));
    check({tag, ".mem_addr"}, mem_addr, exp_addr);
    if (we) begin
      check({tag, ".mem_wdata"}, mem_wdata, wdata);
      check({tag, ".mem_wstrb"}, 32'(mem_wstrb), 32'(wstrb));
    end
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    drain(tag);
    check({tag, ".req_dropped"}, 32'(mem_req), 32'd0);
    check({tag, ".stall_done"}, 32'(stall), 32'd0);
    tick();
  endtask

  task automatic mis_op(input string tag, input logic [11:0] op, input logic [31:0] a,
                        input logic [4:0] rd);
    push(1'b0, rd, '0, 1'b0, 1'b1, 1'b0);
    issue(op, a, 32'hCAFE_F00D, rd);
    @(negedge clk);
    check({tag, ".stall"}, 32'(stall), 32'd0);
    tick();
    idle_in();
    drain(tag);
    check({tag, ".no_req"}, 32'(mem_req), 32'd0);
    tick();
    @(negedge clk);
    check({tag, ".pulse_end"}, 32'(misaligned), 32'd0);
    check({tag, ".wb_end"}, 32'(wb_valid), 32'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.wb_valid", 32'(wb_valid), 32'd0);
    check("rst.wb_data", wb_data, 32'd0);
    check("rst.wb_rd", 32'(wb_rd), 32'd0);
    check("rst.misaligned", 32'(misaligned), 32'd0);
    check("rst.bus_err", 32'(bus_err), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // PASS add followed back-to-back by a branch.
    push(1'b1, 5'd5, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
    issue(OP_ADD, 32'h0000_1234, 32'h0, 5'd5);
    @(negedge clk);
    check("add.stall", 32'(stall), 32'd0);
    tick();
    push(1'b0, 5'd6, 32'h0, 1'b0, 1'b0, 1'b0);
    issue(OP_BEQ, 32'h0000_0040, 32'h0, 5'd6);
    drain("add");
    check("beq.stall", 32'(stall), 32'd0);
    tick();
    idle_in();
    drain("beq");
    tick();
    @(negedge clk);
    check("hold.wb_valid", 32'(wb_valid), 32'd0);
    check("hold.wb_rd", 32'(wb_rd), 32'd6);
    tick();

    // PASS with rd=0 must not write.
    push(1'b0, 5'd0, 32'h0000_0077, 1'b1, 1'b0, 1'b0);
    issue(OP_ADD, 32'h0000_0077, 32'h0, 5'd0);
    tick();
    idle_in();
    drain("add_x0");
    tick();

    // Loads.
    push(1'b1, 5'd7, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0);
    mem_op("lb", LB, 32'h0000_0103, 32'h0, 5'd7, 2, 32'h80FF_0000, 1'b0, 32'h0, 4'h0);
    push(1'b1, 5'd8, 32'h0000_0080, 1'b1, 1'b0, 1'b0);
    mem_op("lbu", LBU, 32'h0000_0103, 32'h0, 5'd8, 0, 32'h80FF_0000, 1'b0, 32'h0, 4'h0);
    push(1'b1, 5'd9, 32'hFFFF_80FF, 1'b1, 1'b0, 1'b0);
    mem_op("lh", LH, 32'h0000_0102, 32'h0, 5'd9, 1, 32'h80FF_0000, 1'b0, 32'h0, 4'h0);
    push(1'b1, 5'd10, 32'h0000_80FF, 1'b1, 1'b0, 1'b0);
    mem_op("lhu", LHU, 32'h0000_0102, 32'h0, 5'd10, 0, 32'h80FF_0000, 1'b0, 32'h0, 4'h0);
    push(1'b1, 5'd11, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    mem_op("lw", LW, 32'h0000_0100, 32'h0, 5'd11, 3, 32'h1234_5678, 1'b0, 32'h0, 4'h0);

    // Stores.
    push(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    mem_op("sh", SH, 32'h0000_0202, 32'hDEAD_BEEF, 5'd0, 0, 32'h0, 1'b1, 32'hBEEF_BEEF, 4'b1100);
    push(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    mem_op("sb", SB, 32'h0000_0001, 32'h0000_00AB, 5'd0, 1, 32'h0, 1'b1, 32'hABAB_ABAB, 4'b0010);
    push(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    mem_op("sw", SW, 32'h0000_0300, 32'hA5A5_0F0F, 5'd0, 0, 32'h0, 1'b1, 32'hA5A5_0F0F, 4'b1111);

    // Misaligned and undefined-size accesses.
    mis_op("mis_lw", LW, 32'h0000_0101, 5'd3);
    mis_op("mis_sh", SH, 32'h0000_0003, 5'd4);
    mis_op("bad_f3", LD_BAD, 32'h0000_0000, 5'd12);

    // mem_ack while idle is ignored.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    check("stray_ack.wb_valid", 32'(wb_valid), 32'd0);
    check("stray_ack.mem_req", 32'(mem_req), 32'd0);
    tick();

    // Timeout: request held for TIMEOUT cycles, then bus_err.
    push(1'b0, 5'd13, 32'h0, 1'b0, 1'b0, 1'b1);
    issue(LW, 32'h0000_0400, 32'h0, 5'd13);
    @(negedge clk);
    check("to.stall_accept", 32'(stall), 32'd1);
    tick();
    idle_in();
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      check("to.req_high", 32'(mem_req), 32'd1);
      tick();
    end
    drain("timeout");
    check("to.req_low", 32'(mem_req), 32'd0);
    check("to.stall_low", 32'(stall), 32'd0);
    tick();
    push(1'b1, 5'd14, 32'h0000_0ABC, 1'b1, 1'b0, 1'b0);
    issue(OP_ADD, 32'h0000_0ABC, 32'h0, 5'd14);
    @(negedge clk);
    check("to.bus_err_pulse_end", 32'(bus_err), 32'd0);
    check("to.pass_stall", 32'(stall), 32'd0);
    tick();
    idle_in();
    drain("after_timeout");
    tick();

    // Reset in the middle of an access drops the request asynchronously.
    issue(LW, 32'h0000_0500, 32'h0, 5'd15);
    tick();
    idle_in();
    @(negedge clk);
    check("mid_rst.req_before", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst.mem_req", 32'(mem_req), 32'd0);
    check("mid_rst.stall", 32'(stall), 32'd0);
    check("mid_rst.wb_valid", 32'(wb_valid), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    push(1'b0, 5'd0, 32'hFFFF_80FF, 1'b1, 1'b0, 1'b0);
    mem_op("post_rst_lh_x0", LH, 32'h0000_0102, 32'h0, 5'd0, 1, 32'h80FF_0000, 1'b0, 32'h0, 4'h0);

    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
